// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Queue entries pair each instruction word with the address it was fetched from.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0100;
    localparam logic [31:0] NOP_INSTR    = 32'h6000_0000;

    // Instruction addresses are word aligned; low bits of a target are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_count  = r_wr_ptr - r_rd_ptr;
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head   = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the slot in time for a push into a full queue on the same edge.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch with credit-limited requests,
// an instruction queue toward decode, and redirect handling that drops stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW:0]   w_inflight;
    logic          w_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic [31:0]   w_target;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // valid never depends on ready; a held request keeps its address until it fires,
    // and a redirect withdraws both the request and the decode offer for that cycle.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // Responses are dropped in the redirect cycle itself and while stale ones remain.
    assign w_drop       = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
    assign w_push       = imem_rsp_valid && !w_drop && (!w_full || w_pop);
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};
    assign w_target     = align_word(redirect_pc);

    assign dec_valid = !w_empty && !redirect_valid;
    assign w_pop     = dec_valid && dec_ready;
    assign dec_instr = w_empty ? '0 : w_head.instr;
    assign dec_pc    = w_empty ? '0 : w_head.pc;
    assign occupancy = w_count;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            // Every request in flight is counted, stale or not, so credit stays exact.
            if (w_fire && !imem_rsp_valid)
                r_outstanding <= r_outstanding + CW'(1);
            else if (!w_fire && imem_rsp_valid)
                r_outstanding <= r_outstanding - CW'(1);

            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                if (imem_rsp_valid && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a random instruction memory and decoder around the DUT,
// with a transaction-level model of the fetch queue checked every cycle.
module tb_fetch_unit;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] SIG     = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  occupancy;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .occupancy      (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];   // expected decode queue: {pc, instr}
    logic [31:0] mem_q[$];   // addresses the memory still owes a response for
    logic [31:0] m_fetch_pc;
    logic [31:0] m_rsp_pc;
    int          m_out;
    int          m_drop;
    logic        exp_rv;
    logic        exp_dv;

    int          p_rdy, p_rsp, p_dec, p_redir;
    logic        force_redir;
    logic [31:0] force_pc;
    int          n_fire;
    logic [31:0] last_fire_addr;
    logic        found;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mem_q.delete();
        m_fetch_pc = RST_PC;
        m_rsp_pc   = RST_PC;
        m_out      = 0;
        m_drop     = 0;
        n_fire     = 0;
        last_fire_addr = '0;
    endfunction

    // ---------------- scoreboard compare ----------------
    function automatic void check_outputs();
        exp_rv = !redirect_valid && ((exp_q.size() + m_out) < DEPTH);
        exp_dv = (exp_q.size() != 0) && !redirect_valid;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (exp_dv && dec_valid) begin
            chk("dec_pc", dec_pc, exp_q[0][63:32]);
            chk("dec_instr", dec_instr, exp_q[0][31:0]);
        end
        chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
    endfunction

    // Advance the model by one clock using the inputs of the cycle just checked.
    function automatic void model_step();
        int pre;
        pre = exp_q.size();
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            n_fire++;
            last_fire_addr = imem_req_addr;
        end
        if (redirect_valid) begin
            exp_q.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            m_rsp_pc   = {redirect_pc[31:2], 2'b00};
            m_drop     = m_out - (imem_rsp_valid ? 1 : 0);
            m_out      = m_drop;
        end else begin
            if (exp_dv && dec_ready) void'(exp_q.pop_front());
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    total++;
                    if (pre >= DEPTH) begin
                        bad++;
                        $display("FAIL queue_overflow: got size %0d expected below %0d", pre, DEPTH);
                    end
                    exp_q.push_back({m_rsp_pc, imem_rsp_data});
                    m_rsp_pc += 32'd4;
                end
                m_out--;
            end
            if (exp_rv && imem_req_ready) begin
                m_out++;
                m_fetch_pc += 32'd4;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive();
        if (mem_q.size() > 0 && pct(p_rsp)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q.pop_front() ^ SIG;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = pct(p_rdy);
        dec_ready      = pct(p_dec);
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = pct(p_redir);
        end
    endtask

    task automatic step_a();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic step_b();
        model_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        force_redir    = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
    endtask

    task automatic set_knobs(input int rdy, input int rsp, input int dec, input int redir);
        p_rdy = rdy; p_rsp = rsp; p_dec = dec; p_redir = redir;
    endtask

    task automatic scan_first_dec(input string name, input logic [31:0] pc);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step_a();
            if (dec_valid && !found) begin
                chk({name, "_pc"}, dec_pc, pc);
                chk({name, "_instr"}, dec_instr, pc ^ SIG);
                found = 1'b1;
            end
            step_b();
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        force_redir    = 1'b0;
        force_pc       = '0;
        model_reset();

        // Streaming: one instruction per cycle after two cycles of latency.
        set_knobs(100, 100, 100, 0);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step_a();
            if (k == 0) begin
                chk("stream_first_valid", 32'(imem_req_valid), 32'd1);
                chk("stream_first_addr", imem_req_addr, 32'h0000_0100);
            end
            if (k >= 2) begin
                chk("stream_dec_valid", 32'(dec_valid), 32'd1);
                chk("stream_dec_pc", dec_pc, 32'h0000_0100 + 32'(4 * (k - 2)));
                chk("stream_dec_instr", dec_instr, (32'h0000_0100 + 32'(4 * (k - 2))) ^ SIG);
            end
            step_b();
        end

        // Decode stalled: credit stops requests at DEPTH, one pop buys one request.
        set_knobs(100, 100, 0, 0);
        do_reset();
        repeat (8) begin step_a(); step_b(); end
        step_a();
        chk("stall_occ", 32'(occupancy), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_fires", 32'(n_fire), 32'd4);
        chk("stall_last_addr", last_fire_addr, 32'h0000_010C);
        p_dec = 100;
        step_b();
        p_dec = 0;
        step_a();
        step_b();
        repeat (5) begin step_a(); step_b(); end
        step_a();
        chk("pop_fires", 32'(n_fire), 32'd5);
        chk("pop_last_addr", last_fire_addr, 32'h0000_0110);
        chk("pop_occ", 32'(occupancy), 32'd4);
        step_b();

        // Memory not ready: request held stable.
        set_knobs(0, 100, 100, 0);
        do_reset();
        repeat (5) begin
            step_a();
            chk("hold_valid", 32'(imem_req_valid), 32'd1);
            chk("hold_addr", imem_req_addr, 32'h0000_0100);
            step_b();
        end
        chk("hold_fires", 32'(n_fire), 32'd0);

        // Redirect with two requests outstanding and no response that cycle.
        set_knobs(100, 0, 100, 0);
        do_reset();
        step_a(); step_b();
        step_a();
        force_redir = 1'b1;
        force_pc    = 32'h0000_2000;
        step_b();
        p_rsp = 100;
        step_a();
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("redir_dec_valid", 32'(dec_valid), 32'd0);
        step_b();
        step_a();
        chk("redir_next_addr", imem_req_addr, 32'h0000_2000);
        step_b();
        scan_first_dec("redir", 32'h0000_2000);

        // Misaligned redirect coinciding with a response.
        set_knobs(100, 0, 100, 0);
        do_reset();
        step_a(); step_b();
        step_a(); step_b();
        step_a();
        force_redir = 1'b1;
        force_pc    = 32'h0000_2003;
        p_rsp       = 100;
        step_b();
        p_rsp = 0;
        step_a();
        chk("mis_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("mis_dec_valid", 32'(dec_valid), 32'd0);
        step_b();
        step_a();
        chk("mis_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
        chk("mis_next_addr", imem_req_addr, 32'h0000_2000);
        chk("mis_occ", 32'(occupancy), 32'd0);
        p_rsp = 100;
        step_b();
        scan_first_dec("mis", 32'h0000_2000);

        // Reset asserted with three entries queued.
        set_knobs(100, 100, 0, 0);
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step_a();
            if (occupancy == 3'd3) found = 1'b1;
            else step_b();
        end
        chk("occ3_reached", 32'(found), 32'd1);
        chk("occ3_dec_valid", 32'(dec_valid), 32'd1);
        p_dec = 100;
        do_reset();
        step_a();
        chk("restart_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_req_addr, 32'h0000_0100);
        step_b();

        // Randomized traffic, including a redirect close to the top of memory.
        for (int s = 0; s < 6; s++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(20, 100),
                      $urandom_range(10, 100), $urandom_range(0, 8));
            do_reset();
            if (s == 0) begin
                force_redir = 1'b1;
                force_pc    = 32'hFFFF_FFF6;
                drive();
            end
            repeat (1500) begin step_a(); step_b(); end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the PowerPC-subset decoder.
- Generates sequential word addresses and issues in-order requests to instruction memory.
- Buffers returned 32-bit instruction words with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding in-flight (stale) responses.

Parameters:
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, >= 2.
- RESET_PC, 32'h0000_0100, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in request order; always accepted.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/exception redirect, single-cycle pulse or held.
- redirect_pc  in  32  new fetch address.
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode consumes this cycle.
- dec_instr  out  32  instruction word.
- dec_pc  out  32  address of dec_instr.
- occupancy  out  $clog2(DEPTH)+1  queue entries held.

Behaviour:
- Reset (async assert, sync-deasserted upstream): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, occupancy=0.
- Request credit: imem_req_valid = !redirect_valid && (occupancy + outstanding < DEPTH). imem_req_addr = fetch_pc. Fire = valid && ready; on fire fetch_pc += 4 (wraps at 2^32). Valid and addr stay stable while ready is low, unless a redirect occurs.
- outstanding counts every in-flight request, stale ones included: +1 on fire, -1 on rsp_valid; both in the same cycle leaves it unchanged.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc += 4.
  - Queue is registered: a response at cycle N gives dec_valid at N+1.
- Decode side: dec_valid = !empty && !redirect_valid; dec_instr/dec_pc are the head entry. Pop on dec_valid && dec_ready. Push and pop in the same cycle leaves occupancy unchanged.
- Full: push into a full queue is impossible by construction of the credit rule; the bench carries an assertion for it.
- Redirect cycle (redirect_valid=1):
  - Queue cleared.
  - No request issued; no pop.
  - fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are silently cleared.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0); that response, if present, is discarded.
  - Requests resume the following cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each cycle.
- Reset mid-operation: all state returns immediately to reset values. Responses to pre-reset requests are the memory's responsibility (memory is reset too).

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}
  - RESET_VECTOR constant 32'h0000_0100
  - NOP_INSTR constant 32'h6000_0000 (ori 0,0,0)
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, empty, full, count; pointer width $clog2(DEPTH) plus wrap bit.
- fetch_unit holds the PC registers, credit/outstanding/drop counters, and handshake logic.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory latency returning addr^32'hA5A5_0000, dec_ready=1 -> addresses 0x100, 0x104, 0x108…; first dec output pc=0x100, instr=0xA5A5_0100, one instruction per cycle steady state.
- dec_ready=0 from start -> exactly 4 requests issued (0x100–0x10C), then imem_req_valid=0, occupancy=4; one pop -> single request 0x110.
- imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and addr=0x100 held constant; no fetch_pc advance.
- Redirect_pc=0x2000 with 2 requests outstanding and no response that cycle -> next 2 responses dropped, queue empty; first dec output pc=0x2000.
- Redirect_pc=0x2003 coincident with a response -> response discarded, next fetch addr 0x2000, drop_cnt = outstanding-1.
- Reset asserted mid-stream with occupancy=3 -> dec_valid=0 and occupancy=0 same cycle (async); after release, fetch restarts at 0x100.
